mips_boot_controller: RTL
=========================

# mips_boot_controller

Boot and run sequencer for the single-cycle MIPS core. It receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit words written to the instruction memory write port. It holds the core in reset while loading, then releases it and counts execution cycles. It stops the core when a self-loop halt or a cycle timeout is detected. It sits between the external loader link and the MIPS top level and owns the core's reset.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of instruction address and PC
- DATA_WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word)
- IMEM_DEPTH, 256, instruction memory depth in words; maximum loadable N
- CNT_WIDTH, 32, width of cycle counter
- MAX_CYCLES, 100000, run timeout in core cycles

Ports:
- CLK  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  level sampled each cycle; begins a load from IDLE, HALT or ERR
- rx_data  in  8  image byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts byte this cycle
- imem_wen  out  1  instruction memory write enable, one-cycle pulse per word
- imem_waddr  out  ADDRESS_WIDTH  byte address of word, 4*k
- imem_wdata  out  DATA_WIDTH  packed word
- core_rst  out  1  active-low reset driven to MIPS core
- core_pc  in  ADDRESS_WIDTH  core PC, monitored in RUN
- busy  out  1  high in LEN0, LEN1, DATA, RUN
- done  out  1  high in HALT
- error  out  1  high in ERR
- cycle_count  out  CNT_WIDTH  core cycles executed in last/current run

## Operation
- Image format: 2-byte little-endian word count N, then 4*N bytes, each word little-endian (first byte to bits 7:0).
- States: IDLE, LEN0, LEN1, DATA, RUN, HALT, ERR.
- IDLE: start=1 -> LEN0. Clears done, error and cycle_count.
- LEN0: low byte of N on handshake -> LEN1.
- LEN1: high byte on handshake. N==0 or N>IMEM_DEPTH -> ERR; otherwise -> DATA with word index k=0 and byte index b=0.
- DATA: each handshake stores the byte at lane b, then b++.
  - On b==3, the assembled word is registered to imem_wdata, imem_waddr=4*k, imem_wen=1 in the next cycle, then k++.
  - After word N-1 is written -> RUN.
- rx_ready=1 only in LEN0, LEN1 and DATA; 0 elsewhere, including the write cycle after the last word.
- RUN: core_rst=1 and cycle_count increments every cycle.
  - The previous core_pc is registered. From the second RUN cycle, core_pc equal to the previous PC -> HALT.
  - cycle_count reaching MAX_CYCLES -> ERR.
- HALT and ERR: core_rst=0, cycle_count frozen. start=1 -> LEN0, clearing flags and count.
- start is ignored in LEN0, LEN1, DATA and RUN. Bytes presented outside LEN/DATA are not accepted.

## Timing
- Reset (rst=0 at edge) applies from any state, including mid-load and mid-run:
  - state=IDLE, rx_ready=0, imem_wen=0, imem_waddr=0, imem_wdata=0.
  - core_rst=0, busy=0, done=0, error=0, cycle_count=0.
  - Partial words are discarded.
- A byte is accepted on an edge where rx_valid&rx_ready. rx_data must be stable while rx_valid=1 and rx_ready=0.
- Word write latency: imem_wen asserts exactly 1 cycle after the 4th byte handshake. The next byte may be accepted in that same cycle.
- RUN entry: first cycle with core_rst=1 is the cycle after the last imem_wen pulse. cycle_count=1 at the end of that cycle.
- Halt detect: state becomes HALT on the edge after the second consecutive equal PC sample. core_rst=0 from that cycle.
- Timeout: when cycle_count==MAX_CYCLES, state becomes ERR on the next edge; the count holds at MAX_CYCLES.
- cycle_count saturates and never wraps. k never exceeds N-1.

## Structure
- Package mips_boot_pkg: state enum (IDLE..ERR), LEN_BYTES=2, BYTES_PER_WORD=4, and a lane index type.
- Sub-module mips_word_packer: byte-lane shift/assembly register with b counter. It outputs a word_valid pulse and the packed word.
- The FSM, the address/k counter, the run monitor and cycle_count live in the top.

## Test plan
- Reset mid-DATA (after 6 bytes of a 2-word image) -> all outputs reset values. A following full load writes from address 0.
- N=2, bytes 02 00 78 56 34 12 EF BE AD DE -> imem writes 0x12345678@0 and 0xDEADBEEF@4. core_rst rises 1 cycle after the second write.
- N=0 and N=IMEM_DEPTH+1 -> ERR, error=1, core_rst=0, no imem_wen.
- rx_valid toggling randomly during a load -> identical writes. No byte is accepted while rx_ready=0.
- RUN with core_pc sequence 0,4,8,8 -> HALT on the edge after the second 8. done=1, cycle_count=4, core_rst=0.
- MAX_CYCLES=10 with PC always incrementing -> ERR with cycle_count=10. A subsequent start reloads and clears error.

Source files
------------

// File: rtl/mips_boot_controller_pkg.sv
// Shared types for the MIPS boot controller: sequencer states, image
// framing constants and the byte-lane index type.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    RUN,
    HALT,
    ERR
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] lane_t;

endpackage

// File: rtl/mips_boot_controller_if.sv
// Loader link, instruction-memory write port, core control and status
// bundle between the boot controller (slave) and its environment (master).
interface mips_boot_controller_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32
);

  logic                     start;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     imem_wen;
  logic [ADDRESS_WIDTH-1:0] imem_waddr;
  logic [DATA_WIDTH-1:0]    imem_wdata;
  logic                     core_rst;
  logic [ADDRESS_WIDTH-1:0] core_pc;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [CNT_WIDTH-1:0]     cycle_count;

  modport master (
    output start, rx_data, rx_valid, core_pc,
    input  rx_ready, imem_wen, imem_waddr, imem_wdata, core_rst,
           busy, done, error, cycle_count
  );

  modport slave (
    input  start, rx_data, rx_valid, core_pc,
    output rx_ready, imem_wen, imem_waddr, imem_wdata, core_rst,
           busy, done, error, cycle_count
  );

endinterface

// File: rtl/mips_boot_controller_packer.sv
// Packs accepted bytes little-endian into 32-bit words; emits a one-cycle
// word_valid pulse with the registered word after every fourth byte.
module mips_word_packer
  import mips_boot_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  lane_t                 lane_q, lane_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // New bytes enter at the top, so the first byte ends up in bits 7:0.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[DATA_WIDTH-1:8]};
      if (lane_q == lane_t'(BYTES_PER_WORD - 1)) begin
        word_d  = shift_d;
        valid_d = 1'b1;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + lane_t'(1);
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/mips_boot_controller.sv
// Boot/run sequencer: loads a length-prefixed byte image into instruction
// memory, then releases the core and watches for a PC self-loop or timeout.
module mips_boot_controller
  import mips_boot_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int IMEM_DEPTH    = 256,
  parameter int CNT_WIDTH     = 32,
  parameter int MAX_CYCLES    = 100000
) (
  input logic                   CLK,
  input logic                   rst,
  mips_boot_controller_if.slave bus
);

  localparam int LEN_W = 8 * LEN_BYTES;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         n_q, n_d;
  logic [LEN_W-1:0]         k_q, k_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [LEN_W-1:0]         n_full;
  logic                     rx_ready, accept, last_word, word_valid;
  logic [DATA_WIDTH-1:0]    word;

  // Ready drops in the write cycle of the final word so no stray byte leaks in.
  assign last_word = (k_q == n_q - LEN_W'(1));
  assign rx_ready  = (state_q == LEN0) || (state_q == LEN1) ||
                     ((state_q == DATA) && !(word_valid && last_word));
  assign accept    = bus.rx_valid && rx_ready;
  assign n_full    = {bus.rx_data, n_q[7:0]};

  mips_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk          (CLK),
    .rst          (rst),
    .clear_i      (state_q != DATA),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, HALT, ERR: begin
        if (bus.start) begin
          state_d = LEN0;
          cnt_d   = '0;
        end
      end
      LEN0: begin
        if (accept) begin
          n_d[7:0] = bus.rx_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          n_d = n_full;
          k_d = '0;
          if ((n_full == '0) || (int'(n_full) > IMEM_DEPTH)) state_d = ERR;
          else                                               state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) begin
          if (last_word) state_d = RUN;
          else           k_d     = k_q + LEN_W'(1);
        end
      end
      RUN: begin
        pc_d = bus.core_pc;
        // A nonzero count means a previous PC sample exists to compare against.
        if (cnt_q == CNT_WIDTH'(MAX_CYCLES)) begin
          state_d = ERR;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          if ((cnt_q != '0) && (bus.core_pc == pc_q)) state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_ready    = rx_ready;
  assign bus.imem_wen    = word_valid;
  assign bus.imem_waddr  = ADDRESS_WIDTH'({k_q, 2'b00});
  assign bus.imem_wdata  = word;
  assign bus.core_rst    = (state_q == RUN);
  assign bus.busy        = (state_q == LEN0) || (state_q == LEN1) ||
                           (state_q == DATA) || (state_q == RUN);
  assign bus.done        = (state_q == HALT);
  assign bus.error       = (state_q == ERR);
  assign bus.cycle_count = cnt_q;

endmodule
